chunked_addsub: RTL and testbench

- Multi-cycle, parametrised N-bit adder/subtractor that processes K bits per clock.
- Carry is registered between chunks, so the critical path is one K-bit ripple instead of N.
- Replaces the combinational ALU adder on long-latency arithmetic paths (e.g. multiply/divide step units) in the MIPS datapath.
- Reports N/Z/C/V flags and uses a start/busy/done handshake.

---
 rtl/chunked_addsub.sv | 114 +++++++++++
 tb/tb_chunked_addsub.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// chunked_addsub: N-bit add/sub processed K bits per cycle with a registered inter-chunk carry; CHUNKED_ADDSUB_SAT_EN enables saturation.
// Latency: done pulses N/K cycles after the accept edge; Sum and flags change only on that edge.
// Backpressure: none; start is sampled only while idle and is dropped (never queued) while busy.
module chunked_addsub #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Sum,
    output logic         FlagN,
    output logic         FlagZ,
    output logic         FlagC,
    output logic         FlagV
);

    localparam int P  = N / K;
    localparam int IW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_q, b_q, acc_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic [K:0]     chunk_sum;
    logic           msb_cin;
    logic           ovf;
    logic           last;
    logic [N-1:0]   res_full;
    logic [N-1:0]   sum_nxt;

    assign last = (idx_q == IW'(P - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Operands shift right so the active chunk is always the low K bits;
    // the accumulator fills from the top so chunk 0 lands at bit 0 after P passes.
    always_comb begin
        chunk_sum = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
        msb_cin   = a_q[K-1] ^ b_q[K-1] ^ chunk_sum[K-1];
        ovf       = chunk_sum[K] ^ msb_cin;
        res_full  = N'({chunk_sum[K-1:0], acc_q} >> K);
        sum_nxt   = res_full;
`ifdef CHUNKED_ADDSUB_SAT_EN
        if (ovf) sum_nxt = res_full[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            done    <= 1'b0;
            Sum     <= '0;
            FlagN   <= 1'b0;
            FlagZ   <= 1'b0;
            FlagC   <= 1'b0;
            FlagV   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_q     <= A;
                    b_q     <= sub ? ~B : B;
                    carry_q <= sub ? 1'b1 : Cin;
                    idx_q   <= '0;
                end
            end else begin
                a_q     <= a_q >> K;
                b_q     <= b_q >> K;
                acc_q   <= res_full;
                carry_q <= chunk_sum[K];
                idx_q   <= idx_q + IW'(1);
                if (last) begin
                    idx_q <= '0;
                    Sum   <= sum_nxt;
                    FlagN <= sum_nxt[N-1];
                    FlagZ <= (sum_nxt == '0);
                    FlagC <= chunk_sum[K];
                    FlagV <= ovf;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub: 32/8 main instance plus 16/16 and 8/1 sweep instances.
module tb_chunked_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, sub, Cin;
    logic [31:0] A, B, Sum;
    logic        busy, done, FlagN, FlagZ, FlagC, FlagV;

    logic        s16_start, s16_sub, s16_cin;
    logic [15:0] s16_a, s16_b, s16_sum;
    logic        s16_busy, s16_done, s16_n, s16_z, s16_c, s16_v;

    logic        s8_start, s8_sub, s8_cin;
    logic [7:0]  s8_a, s8_b, s8_sum;
    logic        s8_busy, s8_done, s8_n, s8_z, s8_c, s8_v;

    int checks = 0;
    int errors = 0;

    chunked_addsub #(.N(32), .K(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum),
        .FlagN(FlagN), .FlagZ(FlagZ), .FlagC(FlagC), .FlagV(FlagV)
    );

    chunked_addsub #(.N(16), .K(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .sub(s16_sub), .A(s16_a), .B(s16_b), .Cin(s16_cin),
        .busy(s16_busy), .done(s16_done), .Sum(s16_sum),
        .FlagN(s16_n), .FlagZ(s16_z), .FlagC(s16_c), .FlagV(s16_v)
    );

    chunked_addsub #(.N(8), .K(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .A(s8_a), .B(s8_b), .Cin(s8_cin),
        .busy(s8_busy), .done(s8_done), .Sum(s8_sum),
        .FlagN(s8_n), .FlagZ(s8_z), .FlagC(s8_c), .FlagV(s8_v)
    );

    // Full-width reference: returns {sum[31:0], N, Z, C, V} for an n-bit operation.
    function automatic logic [35:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic ci, input int n);
        logic [63:0] mask, m1, bb, full, low, c0, r;
        logic        c, cm, v;
        mask = (64'd1 << n) - 64'd1;
        m1   = (64'd1 << (n - 1)) - 64'd1;
        bb   = s ? (~{32'd0, b}) & mask : {32'd0, b};
        c0   = s ? 64'd1 : {63'd0, ci};
        full = {32'd0, a} + bb + c0;
        r    = full & mask;
        c    = full[n];
        low  = ({32'd0, a} & m1) + (bb & m1) + c0;
        cm   = low[n-1];
        v    = c ^ cm;
`ifdef CHUNKED_ADDSUB_SAT_EN
        if (v) r = r[n-1] ? m1 : (64'd1 << (n - 1));
`endif
        return {r[31:0], r[n-1], (r == 64'd0), c, v};
    endfunction

    // Issues one operation on the main instance from an idle cycle; returns cycles to done (-1 on timeout).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ci,
                         output int lat);
        A = a; B = b; sub = s; Cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; sub = 0; Cin = 0; A = 0; B = 0;
        s16_start = 0; s16_sub = 0; s16_cin = 0; s16_a = 0; s16_b = 0;
        s8_start = 0; s8_sub = 0; s8_cin = 0; s8_a = 0; s8_b = 0;
        #2;
        checks++;
        if ({busy, done, Sum, FlagN, FlagZ, FlagC, FlagV} !== 38'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", {busy, done, Sum, FlagN, FlagZ, FlagC, FlagV});
        end
        checks++;
        if ({s16_busy, s16_done, s8_busy, s8_done} !== 4'd0) begin
            errors++;
            $display("FAIL reset_sweep got %b want 0000", {s16_busy, s16_done, s8_busy, s8_done});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        int lat;
        logic [35:0] got;
        logic [35:0] exp_ovf;
`ifdef CHUNKED_ADDSUB_SAT_EN
        exp_ovf = {32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_ovf = {32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        do_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, lat);
        got = {Sum, FlagN, FlagZ, FlagC, FlagV};
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL ovf_latency got %0d want 4", lat); end
        checks++;
        if (got !== exp_ovf) begin errors++; $display("FAIL ovf_result got %h want %h", got, exp_ovf); end

        do_op(32'd5, 32'd5, 1'b1, 1'b0, lat);
        got = {Sum, FlagN, FlagZ, FlagC, FlagV};
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL subzero_latency got %0d want 4", lat); end
        checks++;
        if (got !== {32'h0, 4'b0110}) begin errors++; $display("FAIL subzero_result got %h want %h", got, {32'h0, 4'b0110}); end

        do_op(32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, lat);
        got = {Sum, FlagN, FlagZ, FlagC, FlagV};
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL ripple_latency got %0d want 4", lat); end
        checks++;
        if (got !== {32'h0, 4'b0110}) begin errors++; $display("FAIL ripple_result got %h want %h", got, {32'h0, 4'b0110}); end

        // Cin must be ignored on subtract: 3 - 5 borrows.
        do_op(32'd3, 32'd5, 1'b1, 1'b1, lat);
        got = {Sum, FlagN, FlagZ, FlagC, FlagV};
        checks++;
        if (got !== {32'hFFFFFFFE, 4'b1000}) begin errors++; $display("FAIL sub_cin_ignored got %h want %h", got, {32'hFFFFFFFE, 4'b1000}); end
    endtask

    task automatic test_start_while_busy();
        int npulse;
        logic [35:0] got;
        npulse = 0;
        got = '0;
        A = 32'd1; B = 32'd2; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        A = 32'd100; B = 32'd200;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                checks++;
                if ({busy, Sum, FlagN, FlagZ, FlagC, FlagV} !== {1'b1, 32'hFFFFFFFE, 4'b1000}) begin
                    errors++;
                    $display("FAIL busy_hold cyc %0d got %h want %h", c,
                             {busy, Sum, FlagN, FlagZ, FlagC, FlagV}, {1'b1, 32'hFFFFFFFE, 4'b1000});
                end
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                npulse++;
                got = {Sum, FlagN, FlagZ, FlagC, FlagV};
            end
        end
        checks++;
        if (npulse !== 1) begin errors++; $display("FAIL ignore_start_pulses got %0d want 1", npulse); end
        checks++;
        if (got !== {32'd3, 4'b0000}) begin errors++; $display("FAIL ignore_start_result got %h want %h", got, {32'd3, 4'b0000}); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        logic [35:0] got;
        do_op(32'd10, 32'd20, 1'b0, 1'b0, lat);
        checks++;
        if ({Sum, FlagN, FlagZ, FlagC, FlagV} !== {32'd30, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_first got %h want %h", {Sum, FlagN, FlagZ, FlagC, FlagV}, {32'd30, 4'b0000});
        end
        A = 32'd7; B = 32'd8; sub = 1'b1; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat2 = -1;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat2 = c;
                break;
            end
        end
        got = {Sum, FlagN, FlagZ, FlagC, FlagV};
        checks++;
        if (lat2 !== 5) begin errors++; $display("FAIL b2b_spacing got %0d want 5", lat2); end
        checks++;
        if (got !== {32'hFFFFFFFF, 4'b1000}) begin errors++; $display("FAIL b2b_second got %h want %h", got, {32'hFFFFFFFF, 4'b1000}); end
    endtask

    task automatic test_reset_mid_op();
        int lat, npulse;
        A = 32'h11111111; B = 32'h22222222; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Sum, FlagN, FlagZ, FlagC, FlagV} !== 38'd0) begin
            errors++;
            $display("FAIL midreset_clear got %h want 0", {busy, done, Sum, FlagN, FlagZ, FlagC, FlagV});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        checks++;
        if (npulse !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", npulse); end
        do_op(32'd2, 32'd3, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL post_reset_latency got %0d want 4", lat); end
        checks++;
        if ({Sum, FlagN, FlagZ, FlagC, FlagV} !== {32'd5, 4'b0000}) begin
            errors++;
            $display("FAIL post_reset_result got %h want %h", {Sum, FlagN, FlagZ, FlagC, FlagV}, {32'd5, 4'b0000});
        end
    endtask

    task automatic test_sweep_n16_k16();
        logic [35:0] e;
        logic [15:0] a, b;
        logic        s, ci;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       begin a = 16'h7FFF; b = 16'h0001; s = 1'b0; ci = 1'b0; end
                1:       begin a = 16'h8000; b = 16'h0001; s = 1'b1; ci = 1'b0; end
                2:       begin a = 16'h1234; b = 16'h1234; s = 1'b1; ci = 1'b0; end
                default: begin a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); ci = 1'($urandom); end
            endcase
            e = golden({16'd0, a}, {16'd0, b}, s, ci, 16);
            s16_a = a; s16_b = b; s16_sub = s; s16_cin = ci; s16_start = 1'b1;
            @(posedge clk); #1;
            s16_start = 1'b0;
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (s16_done) begin lat = c; break; end
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL n16_latency vec %0d got %0d want 1", i, lat); end
            checks++;
            if ({s16_sum, s16_n, s16_z, s16_c, s16_v} !== {e[19:4], e[3:0]}) begin
                errors++;
                $display("FAIL n16_result vec %0d got %h want %h", i, {s16_sum, s16_n, s16_z, s16_c, s16_v}, {e[19:4], e[3:0]});
            end
        end
    endtask

    task automatic test_sweep_n8_k1();
        logic [35:0] e;
        logic [7:0]  a, b;
        logic        s, ci;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       begin a = 8'h7F; b = 8'h01; s = 1'b0; ci = 1'b0; end
                1:       begin a = 8'h80; b = 8'h01; s = 1'b1; ci = 1'b0; end
                2:       begin a = 8'hFF; b = 8'h00; s = 1'b0; ci = 1'b1; end
                default: begin a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); ci = 1'($urandom); end
            endcase
            e = golden({24'd0, a}, {24'd0, b}, s, ci, 8);
            s8_a = a; s8_b = b; s8_sub = s; s8_cin = ci; s8_start = 1'b1;
            @(posedge clk); #1;
            s8_start = 1'b0;
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (s8_done) begin lat = c; break; end
            end
            checks++;
            if (lat !== 8) begin errors++; $display("FAIL n8_latency vec %0d got %0d want 8", i, lat); end
            checks++;
            if ({s8_sum, s8_n, s8_z, s8_c, s8_v} !== {e[11:4], e[3:0]}) begin
                errors++;
                $display("FAIL n8_result vec %0d got %h want %h", i, {s8_sum, s8_n, s8_z, s8_c, s8_v}, {e[11:4], e[3:0]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep_n16_k16();
        test_sweep_n8_k1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
